wb_qspi_arb: RTL and testbench

//  Two-master Wishbone arbiter/sequencer in front of the single-port QSPI memory controller (wb_qspi_mem).

---
 rtl/qspi_arb_pkg.sv | 14 +
 rtl/qspi_arb_ibuf.sv | 40 ++++
 rtl/wb_qspi_arb.sv | 155 +++++++++++++++
 tb/tb_wb_qspi_arb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_arb_pkg.sv
// Shared types and region decode for the two-master Wishbone to QSPI arbiter.
package qspi_arb_pkg;

  typedef enum logic [2:0] {IDLE, BUSY, RESP, DROP, HIT} arb_state_e;
  typedef enum logic {IBUS = 1'b0, DBUS = 1'b1} master_e;

  localparam int unsigned RAM_SEL_BIT_DEF = 24;

  // RAM lives where the selecting byte-address bit is set, ROM where it is clear
  function automatic logic is_ram(input logic [31:0] adr, input logic [4:0] sel_bit);
    return adr[sel_bit];
  endfunction

endpackage

// File: rtl/qspi_arb_ibuf.sv
// One-entry instruction buffer: tag is {region, word address}, refilled on every ibus memory read.
module qspi_arb_ibuf #(
  parameter int ADR_W = 22
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADR_W:0]   lookup_tag,
  output logic             hit,
  output logic [31:0]      hit_data,
  input  logic             fill,
  input  logic [ADR_W:0]   fill_tag,
  input  logic [31:0]      fill_data,
  input  logic             inval,
  input  logic [ADR_W:0]   inval_tag
);

  logic             valid;
  logic [ADR_W:0]   tag;
  logic [31:0]      data;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      valid <= 1'b0;
    else if (fill)
      valid <= 1'b1;
    else if (inval && inval_tag == tag)
      valid <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag  <= fill_tag;
      data <= fill_data;
    end
  end

  assign hit      = valid && (lookup_tag == tag);
  assign hit_data = data;

endmodule

// File: rtl/wb_qspi_arb.sv
// Round-robin ibus/dbus arbiter in front of the QSPI memory controller.
// Optional instruction buffer enabled by defining QSPI_ARB_IBUF_EN.
module wb_qspi_arb
  import qspi_arb_pkg::*;
#(
  parameter int RAM_SEL_BIT = 24,
  parameter int ADR_W       = 22
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ibus_stb_i,
  input  logic [31:0]       ibus_adr_i,
  output logic              ibus_ack_o,
  output logic [31:0]       ibus_dat_o,
  input  logic              dbus_stb_i,
  input  logic              dbus_we_i,
  input  logic [3:0]        dbus_be_i,
  input  logic [31:0]       dbus_adr_i,
  input  logic [31:0]       dbus_dat_i,
  output logic              dbus_ack_o,
  output logic [31:0]       dbus_dat_o,
  output logic              mem_sel_rom_ram_o,
  output logic              mem_stb_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADR_W-1:0]  mem_adr_o,
  output logic [31:0]       mem_dat_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_dat_i
);

  localparam logic [4:0] SEL_BIT = 5'(RAM_SEL_BIT);

  arb_state_e        state;
  master_e           last_grant;
  master_e           grant;
  logic              pick_dbus;
  logic              d_rom_write;
  logic              take_hit;
  logic [31:0]       ibuf_data;
  logic [ADR_W-1:0]  i_wadr;
  logic [ADR_W-1:0]  d_wadr;
  logic              unused_bits;

  assign i_wadr      = ibus_adr_i[ADR_W+1:2];
  assign d_wadr      = dbus_adr_i[ADR_W+1:2];
  assign unused_bits = ^{ibus_adr_i, dbus_adr_i};

  // With both requesting, the master not served last time wins
  assign pick_dbus   = dbus_stb_i && (!ibus_stb_i || last_grant == IBUS);
  assign d_rom_write = dbus_we_i && !is_ram(dbus_adr_i, SEL_BIT);

`ifdef QSPI_ARB_IBUF_EN
  logic ibuf_hit;
  logic ibuf_fill;
  logic ibuf_inval;

  assign ibuf_fill  = (state == BUSY) && mem_ack_i && (grant == IBUS);
  assign ibuf_inval = (state == IDLE) && !take_hit && pick_dbus && dbus_we_i &&
                      is_ram(dbus_adr_i, SEL_BIT);
  assign take_hit   = ibus_stb_i && ibuf_hit;

  qspi_arb_ibuf #(.ADR_W(ADR_W)) u_ibuf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .lookup_tag ({is_ram(ibus_adr_i, SEL_BIT), i_wadr}),
    .hit        (ibuf_hit),
    .hit_data   (ibuf_data),
    .fill       (ibuf_fill),
    .fill_tag   ({mem_sel_rom_ram_o, mem_adr_o}),
    .fill_data  (mem_dat_i),
    .inval      (ibuf_inval),
    .inval_tag  ({1'b1, d_wadr})
  );
`else
  assign take_hit  = 1'b0;
  assign ibuf_data = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= IDLE;
      last_grant        <= IBUS;
      grant             <= IBUS;
      ibus_ack_o        <= 1'b0;
      dbus_ack_o        <= 1'b0;
      mem_stb_o         <= 1'b0;
      mem_sel_rom_ram_o <= 1'b0;
      mem_we_o          <= 1'b0;
      mem_be_o          <= '0;
      mem_adr_o         <= '0;
      mem_dat_o         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_hit) begin
            ibus_ack_o <= 1'b1;
            state      <= HIT;
          end else if (pick_dbus) begin
            last_grant        <= DBUS;
            grant             <= DBUS;
            mem_sel_rom_ram_o <= is_ram(dbus_adr_i, SEL_BIT);
            mem_we_o          <= dbus_we_i;
            mem_be_o          <= dbus_be_i;
            mem_adr_o         <= d_wadr;
            mem_dat_o         <= dbus_dat_i;
            if (d_rom_write) begin
              dbus_ack_o <= 1'b1;
              state      <= DROP;
            end else begin
              mem_stb_o <= 1'b1;
              state     <= BUSY;
            end
          end else if (ibus_stb_i) begin
            last_grant        <= IBUS;
            grant             <= IBUS;
            mem_sel_rom_ram_o <= is_ram(ibus_adr_i, SEL_BIT);
            mem_we_o          <= 1'b0;
            mem_be_o          <= 4'hF;
            mem_adr_o         <= i_wadr;
            mem_stb_o         <= 1'b1;
            state             <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            mem_stb_o <= 1'b0;
            if (grant == IBUS) ibus_ack_o <= 1'b1;
            else               dbus_ack_o <= 1'b1;
            state <= RESP;
          end
        end
        RESP, DROP, HIT: begin
          ibus_ack_o <= 1'b0;
          dbus_ack_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data registers carry no reset; they only change when a word is delivered
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == BUSY && mem_ack_i) begin
        if (grant == IBUS) ibus_dat_o <= mem_dat_i;
        else               dbus_dat_o <= mem_dat_i;
      end else if (state == IDLE && take_hit) begin
        ibus_dat_o <= ibuf_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_qspi_arb.sv
// Bench for wb_qspi_arb: directed vector table, hand sequences and randomized traffic vs a transaction model.
module tb_wb_qspi_arb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ibus_stb_i = 1'b0;
  logic [31:0] ibus_adr_i = '0;
  logic        ibus_ack_o;
  logic [31:0] ibus_dat_o;
  logic        dbus_stb_i = 1'b0;
  logic        dbus_we_i = 1'b0;
  logic [3:0]  dbus_be_i = 4'hF;
  logic [31:0] dbus_adr_i = '0;
  logic [31:0] dbus_dat_i = '0;
  logic        dbus_ack_o;
  logic [31:0] dbus_dat_o;
  logic        mem_sel_rom_ram_o;
  logic        mem_stb_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [21:0] mem_adr_o;
  logic [31:0] mem_dat_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_dat_i = '0;

  wb_qspi_arb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ibus_stb_i(ibus_stb_i), .ibus_adr_i(ibus_adr_i), .ibus_ack_o(ibus_ack_o), .ibus_dat_o(ibus_dat_o),
    .dbus_stb_i(dbus_stb_i), .dbus_we_i(dbus_we_i), .dbus_be_i(dbus_be_i), .dbus_adr_i(dbus_adr_i),
    .dbus_dat_i(dbus_dat_i), .dbus_ack_o(dbus_ack_o), .dbus_dat_o(dbus_dat_o),
    .mem_sel_rom_ram_o(mem_sel_rom_ram_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
    .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model state
  bit          lg_dbus;
  bit          i_pend, d_pend;
  logic [31:0] i_adr_m, d_adr_m, d_dat_m;
  bit          d_we_m;
  logic [3:0]  d_be_m;
  bit          i_known, d_known;
  logic [31:0] i_last, d_last;
  bit          buf_valid;
  int unsigned buf_key;
  logic [31:0] buf_data;
  bit          order_q[$];

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] adr;
    logic [3:0]  be;
    logic [31:0] wdat;
    logic [31:0] rdat;
    bit          exp_mem;
    bit          exp_sel;
    logic [21:0] exp_adr;
    logic [3:0]  exp_be;
    bit          exp_we;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit region(input logic [31:0] adr);
    return ((adr >> 24) & 32'h1) != 0;
  endfunction

  function automatic logic [21:0] word_of(input logic [31:0] adr);
    return 22'((adr >> 2) & 32'h003F_FFFF);
  endfunction

  function automatic int unsigned key_of(input logic [31:0] adr);
    return (int'(region(adr)) << 22) + int'(word_of(adr));
  endfunction

  task automatic do_reset();
    ibus_stb_i = 0; dbus_stb_i = 0; mem_ack_i = 0;
    rst_i = 1;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 0;
    lg_dbus = 0; i_pend = 0; d_pend = 0;
    i_known = 0; d_known = 0; buf_valid = 0;
  endtask

  // Steps one transaction from the IDLE sampling edge to the cycle after its ack
  task automatic do_txn(input bit w_d, input bit kind_mem, input bit kind_hit,
                        input bit e_sel, input logic [21:0] e_adr, input logic [3:0] e_be,
                        input bit e_we, input logic [31:0] e_wdat,
                        input logic [31:0] rdat, input logic [31:0] e_rdat);
    int hold;
    @(posedge clk_i); #1;
    if (kind_mem) begin
      chk("stb_rise", mem_stb_o, 1);
      chk("mem_sel", mem_sel_rom_ram_o, e_sel);
      chk("mem_adr", mem_adr_o, e_adr);
      chk("mem_be", mem_be_o, e_be);
      chk("mem_we", mem_we_o, e_we);
      if (e_we) chk("mem_dat", mem_dat_o, e_wdat);
      chk("early_ack", {ibus_ack_o, dbus_ack_o}, 2'b00);
      hold = $urandom_range(0, 3);
      for (int i = 0; i < hold; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          if (w_d) dbus_stb_i = 0; else ibus_stb_i = 0;
        end
        @(posedge clk_i); #1;
        chk("busy_hold", {mem_stb_o, ibus_ack_o, dbus_ack_o, mem_sel_rom_ram_o, mem_adr_o},
            {1'b1, 2'b00, e_sel, e_adr});
      end
      mem_ack_i = 1; mem_dat_i = rdat;
      @(posedge clk_i); #1;
      mem_ack_i = 0; mem_dat_i = $urandom;
      chk("stb_fall", mem_stb_o, 0);
    end else begin
      chk("no_stb", mem_stb_o, 0);
    end
    chk("ack", {ibus_ack_o, dbus_ack_o}, w_d ? 2'b01 : 2'b10);
    if (kind_mem || kind_hit)
      chk("rdata", w_d ? dbus_dat_o : ibus_dat_o, e_rdat);
    if (w_d ? i_known : d_known)
      chk("loser_dat_hold", w_d ? ibus_dat_o : dbus_dat_o, w_d ? i_last : d_last);
    if (kind_mem || kind_hit) begin
      if (w_d) begin d_last = e_rdat; d_known = 1; end
      else     begin i_last = e_rdat; i_known = 1; end
    end
    if (w_d) dbus_stb_i = 0; else ibus_stb_i = 0;
    @(posedge clk_i); #1;
    chk("ack_one_cycle", {ibus_ack_o, dbus_ack_o, mem_stb_o}, 3'b000);
  endtask

  // Serves every pending request in the order the arbitration rules dictate
  task automatic serve_all();
    bit          hit, w_d, drop, sel;
    logic [31:0] adr, rdat, e_rdat;
    while (i_pend || d_pend) begin
      hit = 0;
`ifdef QSPI_ARB_IBUF_EN
      hit = i_pend && buf_valid && (buf_key == key_of(i_adr_m));
`endif
      if (hit)                  w_d = 0;
      else if (i_pend && d_pend) w_d = !lg_dbus;
      else                      w_d = d_pend;
      adr  = w_d ? d_adr_m : i_adr_m;
      sel  = region(adr);
      drop = w_d && d_we_m && !sel;
      rdat = $urandom;
      e_rdat = hit ? buf_data : rdat;
      if (!hit) begin
        lg_dbus = w_d;
        order_q.push_back(w_d);
        if (w_d && d_we_m && sel && buf_key == key_of(adr)) buf_valid = 0;
      end
      do_txn(w_d, !hit && !drop, hit, sel, word_of(adr), w_d ? d_be_m : 4'hF,
             w_d && d_we_m, d_dat_m, rdat, e_rdat);
      if (!w_d && !hit) begin
        buf_valid = 1; buf_key = key_of(adr); buf_data = rdat;
      end
      if (w_d) d_pend = 0; else i_pend = 0;
    end
  endtask

  task automatic req_i(input logic [31:0] adr);
    ibus_adr_i = adr; ibus_stb_i = 1;
    i_adr_m = adr; i_pend = 1;
  endtask

  task automatic req_d(input bit we, input logic [31:0] adr, input logic [3:0] be, input logic [31:0] dat);
    dbus_we_i = we; dbus_adr_i = adr; dbus_be_i = be; dbus_dat_i = dat; dbus_stb_i = 1;
    d_we_m = we; d_adr_m = adr; d_be_m = be; d_dat_m = dat; d_pend = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pool [8];
    pool = '{32'h0000_0100, 32'h0100_0100, 32'h0100_0020, 32'h0000_0010,
             32'h00FF_FFFC, 32'h01FF_FFFC, 32'h8100_0044, 32'h0100_0008};

    vecs[0] = '{0, 0, 32'h0000_0100, 4'h0, 32'h0,         32'hDEAD_BEEF, 1, 0, 22'h40,     4'hF, 0};
    vecs[1] = '{1, 1, 32'h0100_0008, 4'h6, 32'h1122_3344, 32'h0BAD_F00D, 1, 1, 22'h2,      4'h6, 1};
    vecs[2] = '{1, 1, 32'h0000_0010, 4'hF, 32'hCAFE_0001, 32'h0,         0, 0, 22'h0,      4'hF, 1};
    vecs[3] = '{1, 0, 32'h0100_0FFC, 4'hF, 32'h0,         32'h1234_5678, 1, 1, 22'h3FF,    4'hF, 0};
    vecs[4] = '{0, 0, 32'h00FF_FFFC, 4'h0, 32'h0,         32'hA5A5_5A5A, 1, 0, 22'h3FFFFF, 4'hF, 0};
    vecs[5] = '{1, 0, 32'hFF7F_FFF0, 4'h3, 32'h0,         32'h0F0F_F0F0, 1, 1, 22'h1FFFFC, 4'h3, 0};

    do_reset();
    chk("reset_outputs", {ibus_ack_o, dbus_ack_o, mem_stb_o, mem_sel_rom_ram_o, mem_we_o, mem_be_o},
        9'h0);
    chk("reset_mem_adr_dat", {mem_adr_o, mem_dat_o}, 54'h0);

    // Directed single-master transactions
    foreach (vecs[k]) begin
      if (vecs[k].is_d) begin
        dbus_we_i = vecs[k].we; dbus_adr_i = vecs[k].adr; dbus_be_i = vecs[k].be;
        dbus_dat_i = vecs[k].wdat; dbus_stb_i = 1;
      end else begin
        ibus_adr_i = vecs[k].adr; ibus_stb_i = 1;
      end
      do_txn(vecs[k].is_d, vecs[k].exp_mem, 0, vecs[k].exp_sel, vecs[k].exp_adr, vecs[k].exp_be,
             vecs[k].exp_we, vecs[k].wdat, vecs[k].rdat, vecs[k].rdat);
    end

    // Simultaneous requests after reset alternate starting with dbus
    do_reset();
    order_q.delete();
    req_i(32'h0000_0200); req_d(0, 32'h0100_0300, 4'hF, 32'h0);
    serve_all();
    req_i(32'h0000_0400); req_d(0, 32'h0100_0500, 4'hF, 32'h0);
    serve_all();
    chk("rr_count", order_q.size(), 4);
    if (order_q.size() == 4)
      chk("rr_order", {order_q[0], order_q[1], order_q[2], order_q[3]}, 4'b1010);

    // Reset while BUSY aborts the access without an ack
    req_d(0, 32'h0100_0040, 4'hF, 32'h0);
    @(posedge clk_i); #1;
    chk("pre_reset_stb", mem_stb_o, 1);
    rst_i = 1; mem_ack_i = 1; mem_dat_i = 32'h5555_AAAA;
    @(posedge clk_i); #1;
    rst_i = 0; mem_ack_i = 0; dbus_stb_i = 0;
    lg_dbus = 0; i_pend = 0; d_pend = 0; buf_valid = 0;
    chk("abort_stb_ack", {mem_stb_o, ibus_ack_o, dbus_ack_o}, 3'b000);
    @(posedge clk_i); #1;
    chk("abort_quiet", {mem_stb_o, ibus_ack_o, dbus_ack_o}, 3'b000);
    if (d_known) chk("abort_dat_hold", dbus_dat_o, d_last);
    req_d(1, 32'h0100_0044, 4'h9, 32'h7777_1111);
    serve_all();

`ifdef QSPI_ARB_IBUF_EN
    // Repeat fetch hits the buffer; a matching RAM write forces a miss
    req_i(32'h0100_0020); serve_all();
    req_i(32'h0100_0020); serve_all();
    req_d(1, 32'h0100_0020, 4'hF, 32'h0101_0202); serve_all();
    req_i(32'h0100_0020); serve_all();
`endif

    // Randomized traffic
    for (int it = 0; it < 200; it++) begin
      int pat;
      pat = $urandom_range(1, 3);
      if (pat[0]) req_i(pool[$urandom_range(0, 7)]);
      if (pat[1]) req_d($urandom_range(0, 1), pool[$urandom_range(0, 7)],
                        4'($urandom_range(1, 15)), $urandom);
      serve_all();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
